// File: rtl/loproc_clk_gate_ctrl_pkg.sv
// Shared definitions for the LoPROC v2 clock-gating controller: channel state
// encodings, the stats-counter width default and the hold-counter width helper.
package loproc_clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } ch_state_t;

    localparam int STAT_W_DEFAULT = 16;

    // Hold counter must represent IDLE_CYCLES; a zero-width counter is not allowed.
    function automatic int cnt_width(input int idle);
        return (idle < 1) ? 1 : $clog2(idle + 1);
    endfunction

endpackage

// File: rtl/loproc_icg_cell.sv
// Latch-based integrated clock gate: enable captured while src_clk is low,
// output is latch & src_clk, so no runt pulses. Maps onto a library ICG.
module loproc_icg_cell (
    input  logic src_clk,
    input  logic en,
    input  logic test_en,
    output logic gated_clk
);

    logic latch_q;

    always_latch begin
        if (!src_clk) latch_q <= en | test_en;
    end

    assign gated_clk = latch_q & src_clk;

endmodule

// File: rtl/loproc_clk_gate_ctrl.sv
// Multi-channel clock-gating controller with idle hysteresis and wake handshake.
// Optional per-channel gated-cycle counters: define LOPROC_CLK_GATE_STATS_EN.
module loproc_clk_gate_ctrl
    import loproc_clk_gate_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int STAT_W      = STAT_W_DEFAULT
) (
    input  logic              src_clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] clk_req,
    input  logic              force_on,
    input  logic              test_en,
    output logic [NUM_CH-1:0] gated_clk,
    output logic [NUM_CH-1:0] clk_ack,
    output logic [NUM_CH-1:0] ch_gated
`ifdef LOPROC_CLK_GATE_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [NUM_CH*STAT_W-1:0] gated_cnt
`endif
);

    localparam int             CNT_W     = cnt_width(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES);

    ch_state_t         state     [NUM_CH];
    ch_state_t         state_nxt [NUM_CH];
    logic [CNT_W-1:0]  cnt       [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt   [NUM_CH];
    logic [NUM_CH-1:0] en;

    // Enable is registered from the next state so it settles a full low phase
    // before the ICG latch opens; reset keeps every clock running.
    always_ff @(posedge src_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                state[i] <= ST_RUN;
                cnt[i]   <= '0;
                en[i]    <= 1'b1;
            end else begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
                en[i]    <= (state_nxt[i] != ST_GATED) | force_on;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                ST_RUN: begin
                    if (!clk_req[i]) begin
                        if (IDLE_CYCLES == 0) begin
                            state_nxt[i] = ST_GATED;
                        end else begin
                            state_nxt[i] = ST_HOLD;
                            cnt_nxt[i]   = IDLE_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (clk_req[i]) begin
                        state_nxt[i] = ST_RUN;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_W'(1)) begin
                        state_nxt[i] = ST_GATED;
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i] = cnt[i] - CNT_W'(1);
                    end
                end
                ST_GATED: begin
                    if (clk_req[i]) state_nxt[i] = ST_WAKE;
                end
                ST_WAKE: begin
                    state_nxt[i] = ST_RUN;
                end
                default: begin
                    state_nxt[i] = ST_RUN;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign clk_ack[g]  = (state[g] == ST_RUN) | (state[g] == ST_HOLD) | force_on;
        assign ch_gated[g] = (state[g] == ST_GATED);

        loproc_icg_cell u_icg (
            .src_clk   (src_clk),
            .en        (en[g]),
            .test_en   (test_en),
            .gated_clk (gated_clk[g])
        );
    end

`ifdef LOPROC_CLK_GATE_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_CH];

    // Counts edges the channel actually suppressed (en low), saturating.
    always_ff @(posedge src_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst || stat_clr) begin
                stat_q[i] <= '0;
            end else if (!en[i] && (stat_q[i] != {STAT_W{1'b1}})) begin
                stat_q[i] <= stat_q[i] + STAT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
        assign gated_cnt[g*STAT_W +: STAT_W] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_loproc_clk_gate_ctrl.sv
// Randomized scoreboard bench for loproc_clk_gate_ctrl against a behavioural
// reference model (idle-streak counting) of the gating rules.
module tb_loproc_clk_gate_ctrl;

    localparam int NUM_CH    = 4;
    localparam int IDLE      = 8;
    localparam int STAT_W    = 4;
    localparam int STAT_MAX  = (1 << STAT_W) - 1;
    localparam int W         = 3*NUM_CH + NUM_CH*STAT_W;

    logic              src_clk;
    logic              rst;
    logic [NUM_CH-1:0] clk_req;
    logic              force_on;
    logic              test_en;
    logic              stat_clr;
    logic [NUM_CH-1:0] gated_clk;
    logic [NUM_CH-1:0] clk_ack;
    logic [NUM_CH-1:0] ch_gated;
    logic [NUM_CH*STAT_W-1:0] cnt_act;
`ifdef LOPROC_CLK_GATE_STATS_EN
    logic [NUM_CH*STAT_W-1:0] gated_cnt;
    assign cnt_act = gated_cnt;
`else
    assign cnt_act = '0;
`endif

    loproc_clk_gate_ctrl #(
        .NUM_CH      (NUM_CH),
        .IDLE_CYCLES (IDLE),
        .STAT_W      (STAT_W)
    ) dut (
        .src_clk   (src_clk),
        .rst       (rst),
        .clk_req   (clk_req),
        .force_on  (force_on),
        .test_en   (test_en),
        .gated_clk (gated_clk),
        .clk_ack   (clk_ack),
        .ch_gated  (ch_gated)
`ifdef LOPROC_CLK_GATE_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .gated_cnt (gated_cnt)
`endif
    );

    // clock
    initial src_clk = 1'b0;
    always #5 src_clk = ~src_clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // reference model: a channel gates after IDLE+1 consecutive low samples while running
    logic              m_gated [NUM_CH];
    logic              m_wake  [NUM_CH];
    int                m_streak[NUM_CH];
    logic [NUM_CH-1:0] m_en;
    int                m_cnt   [NUM_CH];

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_gated[i] = 1'b0; m_wake[i] = 1'b0; m_streak[i] = 0; m_cnt[i] = 0;
        end
        m_en = '1;
    endtask

    task automatic model_edge();
        logic [NUM_CH-1:0]        deliv, ack, gtd;
        logic [NUM_CH*STAT_W-1:0] cnt_exp;
        cnt_exp = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            deliv[i] = m_en[i] | test_en;
            if (rst || stat_clr) m_cnt[i] = 0;
            else if (!m_en[i] && m_cnt[i] < STAT_MAX) m_cnt[i] = m_cnt[i] + 1;
            if (rst) begin
                m_gated[i] = 1'b0; m_wake[i] = 1'b0; m_streak[i] = 0;
            end else if (m_wake[i]) begin
                m_wake[i] = 1'b0; m_streak[i] = 0;
            end else if (m_gated[i]) begin
                if (clk_req[i]) begin m_gated[i] = 1'b0; m_wake[i] = 1'b1; end
            end else if (clk_req[i]) begin
                m_streak[i] = 0;
            end else begin
                m_streak[i] = m_streak[i] + 1;
                if (m_streak[i] == IDLE + 1) begin m_gated[i] = 1'b1; m_streak[i] = 0; end
            end
            m_en[i] = !m_gated[i] || force_on;
            ack[i]  = (!m_gated[i] && !m_wake[i]) || force_on;
            gtd[i]  = m_gated[i];
`ifdef LOPROC_CLK_GATE_STATS_EN
            cnt_exp[i*STAT_W +: STAT_W] = STAT_W'(m_cnt[i]);
`endif
        end
        exp_q.push_back({cnt_exp, gtd, ack, deliv});
    endtask

    // driver: called at a negedge, predicts the next posedge, returns at next negedge
    task automatic step(input logic [NUM_CH-1:0] r, input logic f, input logic t,
                        input logic rs, input logic sc);
        clk_req = r; force_on = f; test_en = t; rst = rs; stat_clr = sc;
        model_edge();
        @(negedge src_clk);
    endtask

    // monitor: compares every posedge for which an expectation exists, plus pulse shape
    initial begin
        logic [W-1:0]      exp_w;
        logic [NUM_CH-1:0] exp_hi;
        forever begin
            @(posedge src_clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                exp_hi = exp_w[NUM_CH-1:0];
                n_vec++;
                if ({cnt_act, ch_gated, clk_ack, gated_clk} !== exp_w) begin
                    n_err++;
                    $display("FAIL outputs t=%0t got cnt=%h gated=%b ack=%b clk=%b want %h",
                             $time, cnt_act, ch_gated, clk_ack, gated_clk, exp_w);
                end
                #3;
                n_vec++;
                if (gated_clk !== exp_hi) begin
                    n_err++;
                    $display("FAIL pulse_high t=%0t got %b want %b", $time, gated_clk, exp_hi);
                end
                @(negedge src_clk);
                #1;
                n_vec++;
                if (gated_clk !== '0) begin
                    n_err++;
                    $display("FAIL pulse_low t=%0t got %b want 0000", $time, gated_clk);
                end
            end
        end
    end

    // stimulus
    initial begin
        logic [NUM_CH-1:0] r;
        logic f, t;
        int rate;
        clk_req = '0; force_on = 1'b0; test_en = 1'b0; stat_clr = 1'b0; rst = 1'b1;
        model_reset();
        @(negedge src_clk);

        // reset held three edges with requests low: clocks keep running
        repeat (2) step('0, 0, 0, 1, 0);
        repeat (5) step('1, 0, 0, 0, 0);
        // idle gate on ch0
        repeat (14) step(4'b1110, 0, 0, 0, 0);
        // cancelled gating on ch1
        repeat (3) step(4'b1100, 0, 0, 0, 0);
        repeat (4) step(4'b1110, 0, 0, 0, 0);
        // wake ch0, including a request drop during WAKE
        step(4'b1111, 0, 0, 0, 0);
        step(4'b1110, 0, 0, 0, 0);
        repeat (4) step(4'b1111, 0, 0, 0, 0);
        // gate everything, then overrides
        repeat (12) step('0, 0, 0, 0, 0);
        repeat (3) step('0, 1, 0, 0, 0);
        repeat (2) step('0, 0, 0, 0, 0);
        repeat (3) step('0, 0, 1, 0, 0);
        // long gated stretch for counter saturation, then clear
        repeat (20) step('0, 0, 0, 0, 0);
        step('0, 0, 0, 0, 1);
        repeat (3) step('0, 0, 0, 0, 0);
        step('0, 0, 0, 1, 0);
        repeat (2) step('0, 0, 0, 0, 0);

        r = '1; f = 1'b0; t = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            rate = (c < 400) ? 7 : 23;
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(0, rate) == 0) r[i] = ~r[i];
            if ($urandom_range(0, 40) == 0) f = ~f;
            if ($urandom_range(0, 40) == 0) t = ~t;
            step(r, f, t, ($urandom_range(0, 149) == 0), ($urandom_range(0, 59) == 0));
        end

        repeat (3) @(negedge src_clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
